// File: rtl/level_engine_if.sv
// Pixel bus between the video timing source and the level engine.
// The source presents a pixel coordinate with its qualifier and the
// engine answers with the registered colour for that pixel.
interface level_engine_if #(
    parameter int PA = 12,
    parameter int CA = 4
);
    logic [PA-1:0]      pix_x;
    logic [PA-1:0]      pix_y;
    logic               pix_v;
    logic [2:0][CA-1:0] color;

    modport master (output pix_x, output pix_y, output pix_v, input color);
    modport slave  (input pix_x, input pix_y, input pix_v, output color);
endinterface

// File: rtl/level_engine.sv
// Side-scrolling level engine: a player square runs across NSUB lanes,
// alternating direction, can jump once per landing, dies on touching an
// obstacle and respawns at the lane start after a fixed number of frames.
// Position and jump state move only on the frame tick; collisions are
// found while the beam draws the player over an obstacle.
module level_engine #(
    parameter int PA          = 12,
    parameter int CA          = 4,
    parameter int NSUB        = 3,
    parameter int NOBS        = 3,
    parameter int SCR_W       = 640,
    parameter int PW          = 20,
    parameter int STEP        = 1,
    parameter int JUMP_H      = 40,
    parameter int DEAD_FRAMES = 30,
    parameter int LANE_Y [NSUB]      = '{120, 240, 360},
    parameter int OBS_X  [NSUB*NOBS] = '{0, 0, 0, 300, 100, 0, 0, 400, 0},
    parameter int OBS_Y  [NSUB*NOBS] = '{0, 0, 0, 220, 200, 0, 340, 300, 0},
    parameter int OBS_W  [NSUB*NOBS] = '{0, 0, 0, 20, 0, 0, 20, 40, 0},
    parameter int OBS_H  [NSUB*NOBS] = '{0, 0, 0, 20, 30, 0, 20, 20, 0}
) (
    input  logic                      clk,
    input  logic                      rst,
    level_engine_if.slave             vid,
    input  logic                      imgReturn,
    input  logic                      jump,
    input  logic                      restart,
    input  logic [11:0]               topColor,
    input  logic [11:0]               midColor,
    output logic [$clog2(NSUB+1)-1:0] subLV,
    output logic                      LVcp,
    output logic [7:0]                deaths,
    output logic                      dead
);
    localparam int SW = $clog2(NSUB+1);
    localparam int CW = $clog2(DEAD_FRAMES+1);

    // One extra bit so that box edges above the top of the screen stay negative.
    typedef logic signed [PA:0] coord_t;
    typedef enum logic [1:0] {RUN, DEAD, DONE} state_t;

    localparam coord_t PW_C   = coord_t'(PW);
    localparam coord_t STEP_C = coord_t'(STEP);
    localparam coord_t JH_C   = coord_t'(JUMP_H);

    state_t             stateQ, stateD;
    coord_t             xQ, xD;
    coord_t             jOstQ, jOstD;
    logic               upQ, upD;
    logic [SW-1:0]      subQ, subD;
    logic [7:0]         deathsQ, deathsD;
    logic [CW-1:0]      cntQ, cntD;
    logic               hitQ, hitD;
    logic [2:0][CA-1:0] colorQ, colorD;

    coord_t      px, py, laneY, pTop, pBot;
    logic        inPlayer, inObs, inFloor, hitNow;
    logic        jumpArm, upNext;
    logic [11:0] pixPal;

    // Even lanes run rightwards from the left edge, odd lanes leftwards.
    function automatic coord_t startX(input logic [SW-1:0] s);
        return s[0] ? coord_t'(SCR_W - PW) : coord_t'(0);
    endfunction

    function automatic coord_t endX(input logic [SW-1:0] s);
        return s[0] ? coord_t'(0) : coord_t'(SCR_W - PW);
    endfunction

    // Classify the current pixel against player box, current obstacles and floors.
    always_comb begin
        px    = {1'b0, vid.pix_x};
        py    = {1'b0, vid.pix_y};
        laneY = '0;
        for (int s = 0; s < NSUB; s++)
            if (subQ == SW'(s)) laneY = coord_t'(LANE_Y[s]);
        pTop     = laneY - PW_C - jOstQ;
        pBot     = laneY - jOstQ;
        inPlayer = (stateQ != DONE) && (px >= xQ) && (px < xQ + PW_C) &&
                   (py >= pTop) && (py < pBot);
        inObs    = 1'b0;
        for (int s = 0; s < NSUB; s++)
            for (int o = 0; o < NOBS; o++)
                if ((subQ == SW'(s)) && (OBS_W[s*NOBS+o] != 0) &&
                    (px >= coord_t'(OBS_X[s*NOBS+o])) &&
                    (px <  coord_t'(OBS_X[s*NOBS+o] + OBS_W[s*NOBS+o])) &&
                    (py >= coord_t'(OBS_Y[s*NOBS+o])) &&
                    (py <  coord_t'(OBS_Y[s*NOBS+o] + OBS_H[s*NOBS+o])))
                    inObs = 1'b1;
        inFloor = 1'b0;
        for (int s = 0; s < NSUB; s++)
            if ((py >= coord_t'(LANE_Y[s])) && (py < coord_t'(LANE_Y[s] + 4)))
                inFloor = 1'b1;
        hitNow = vid.pix_v && (stateQ == RUN) && inPlayer && inObs;
        pixPal = '0;
        if (vid.pix_v) begin
            if (inPlayer)     pixPal = (stateQ == RUN) ? midColor : topColor;
            else if (inObs)   pixPal = midColor;
            else if (inFloor) pixPal = topColor;
        end
        for (int c = 0; c < 3; c++)
            colorD[c] = pixPal[4*c+3 -: CA];
    end

    // Next-state logic: restart beats everything, otherwise the frame tick drives the game.
    always_comb begin
        stateD  = stateQ;
        xD      = xQ;
        jOstD   = jOstQ;
        upD     = upQ;
        subD    = subQ;
        deathsD = deathsQ;
        cntD    = cntQ;
        hitD    = hitQ;
        jumpArm = 1'b0;
        upNext  = upQ;
        if (restart) begin
            stateD = RUN;
            xD     = '0;
            jOstD  = '0;
            upD    = 1'b0;
            subD   = '0;
            cntD   = '0;
            hitD   = 1'b0;
        end else begin
            if (hitNow) hitD = 1'b1;
            case (stateQ)
                RUN: begin
                    jumpArm = jump && (jOstQ == '0) && !upQ;
                    upNext  = upQ || jumpArm;
                    upD     = upNext;
                    if (imgReturn) begin
                        hitD = 1'b0;
                        if (hitQ) begin
                            stateD = DEAD;
                            xD     = startX(subQ);
                            jOstD  = '0;
                            upD    = 1'b0;
                            cntD   = '0;
                            if (deathsQ != 8'hFF) deathsD = deathsQ + 8'd1;
                        end else begin
                            if (upNext) begin
                                jOstD = jOstQ + coord_t'(1);
                                upD   = (jOstQ + coord_t'(1)) < JH_C;
                            end else if (jOstQ != '0) begin
                                jOstD = jOstQ - coord_t'(1);
                            end
                            if (xQ == endX(subQ)) begin
                                if (subQ == SW'(NSUB-1)) begin
                                    stateD = DONE;
                                    subD   = SW'(NSUB);
                                end else begin
                                    subD = subQ + SW'(1);
                                    xD   = startX(subQ + SW'(1));
                                end
                            end else if (!subQ[0]) begin
                                xD = (xQ + STEP_C >= endX(subQ)) ? endX(subQ) : xQ + STEP_C;
                            end else begin
                                xD = (xQ - STEP_C <= endX(subQ)) ? endX(subQ) : xQ - STEP_C;
                            end
                        end
                    end
                end
                DEAD: begin
                    if (imgReturn) begin
                        hitD = 1'b0;
                        if (cntQ == CW'(DEAD_FRAMES-1)) begin
                            stateD = RUN;
                            cntD   = '0;
                        end else begin
                            cntD = cntQ + CW'(1);
                        end
                    end
                end
                default: begin
                    if (imgReturn) hitD = 1'b0;
                end
            endcase
        end
    end

    // State and colour registers; reset wins over every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= RUN;
            xQ      <= '0;
            jOstQ   <= '0;
            upQ     <= 1'b0;
            subQ    <= '0;
            deathsQ <= '0;
            cntQ    <= '0;
            hitQ    <= 1'b0;
            colorQ  <= '0;
        end else begin
            stateQ  <= stateD;
            xQ      <= xD;
            jOstQ   <= jOstD;
            upQ     <= upD;
            subQ    <= subD;
            deathsQ <= deathsD;
            cntQ    <= cntD;
            hitQ    <= hitD;
            colorQ  <= colorD;
        end
    end

    assign vid.color = colorQ;
    assign subLV     = subQ;
    assign LVcp      = (stateQ == DONE);
    assign deaths    = deathsQ;
    assign dead      = (stateQ == DEAD);
endmodule

// File: tb/tb_level_engine.sv
// Bench for level_engine: a frame-level behavioural model predicts every
// output after each cycle; predictions go into a scoreboard queue that a
// separate monitor drains and compares mid-cycle.
module tb_level_engine;
    localparam int PA = 12, CA = 4, NSUB = 3, NOBS = 3, SCR_W = 640, PW = 20;
    localparam int STEP = 1, JUMP_H = 40, DEAD_FRAMES = 30;
    localparam int LANE_Y [NSUB]      = '{120, 240, 360};
    localparam int OBS_X  [NSUB*NOBS] = '{0, 0, 0, 300, 100, 0, 0, 400, 0};
    localparam int OBS_Y  [NSUB*NOBS] = '{0, 0, 0, 220, 200, 0, 340, 300, 0};
    localparam int OBS_W  [NSUB*NOBS] = '{0, 0, 0, 20, 0, 0, 20, 40, 0};
    localparam int OBS_H  [NSUB*NOBS] = '{0, 0, 0, 20, 30, 0, 20, 20, 0};

    localparam int K_COLOR = 0, K_SUB = 1, K_LVCP = 2, K_DEATHS = 3, K_DEAD = 4, K_X = 5, K_J = 6;

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } item_t;

    logic        clk;
    logic        rst, imgReturn, jump, restart;
    logic [11:0] topColor, midColor;
    logic [1:0]  subLV;
    logic        LVcp, dead;
    logic [7:0]  deaths;

    level_engine_if #(.PA(PA), .CA(CA)) vif ();

    level_engine #(
        .PA(PA), .CA(CA), .NSUB(NSUB), .NOBS(NOBS), .SCR_W(SCR_W), .PW(PW),
        .STEP(STEP), .JUMP_H(JUMP_H), .DEAD_FRAMES(DEAD_FRAMES),
        .LANE_Y(LANE_Y), .OBS_X(OBS_X), .OBS_Y(OBS_Y), .OBS_W(OBS_W), .OBS_H(OBS_H)
    ) dut (
        .clk(clk), .rst(rst), .vid(vif), .imgReturn(imgReturn), .jump(jump),
        .restart(restart), .topColor(topColor), .midColor(midColor),
        .subLV(subLV), .LVcp(LVcp), .deaths(deaths), .dead(dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    item_t sb[$];
    int    nChecks = 0;
    int    nFails  = 0;

    // Model state: mState 0=running, 1=dead, 2=level done; mJt is the number
    // of ticks since the current jump was accepted, -1 when on the ground.
    int mState, mX, mJt, mSub, mDeaths, mDeadTicks;
    bit mHit;

    function automatic int mJost();
        if (mJt < 0) return 0;
        return (mJt <= JUMP_H) ? mJt : 2*JUMP_H - mJt;
    endfunction

    function automatic int startOf(int s);
        return (s % 2 == 1) ? SCR_W - PW : 0;
    endfunction

    function automatic int endOf(int s);
        return (s % 2 == 1) ? 0 : SCR_W - PW;
    endfunction

    function automatic bit inPlayerM(int x, int y);
        int lane;
        if (mState == 2) return 1'b0;
        lane = LANE_Y[mSub];
        return (x >= mX) && (x < mX + PW) && (y >= lane - PW - mJost()) && (y < lane - mJost());
    endfunction

    function automatic bit inObsM(int x, int y);
        if (mSub >= NSUB) return 1'b0;
        for (int o = 0; o < NOBS; o++) begin
            int k = mSub*NOBS + o;
            if (OBS_W[k] > 0 && x >= OBS_X[k] && x < OBS_X[k] + OBS_W[k] &&
                y >= OBS_Y[k] && y < OBS_Y[k] + OBS_H[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit inFloorM(int y);
        for (int s = 0; s < NSUB; s++)
            if (y >= LANE_Y[s] && y < LANE_Y[s] + 4) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [11:0] expPal(bit pv, int x, int y);
        if (!pv) return 12'h000;
        if (inPlayerM(x, y)) return (mState == 0) ? midColor : topColor;
        if (inObsM(x, y)) return midColor;
        if (inFloorM(y)) return topColor;
        return 12'h000;
    endfunction

    function automatic void modelStep(bit r, bit rs, bit tk, bit jp, bit pv, int x, int y);
        bit hitNow = pv && (mState == 0) && inPlayerM(x, y) && inObsM(x, y);
        if (r) begin
            mState = 0; mX = 0; mJt = -1; mSub = 0; mDeaths = 0; mDeadTicks = 0; mHit = 0;
            return;
        end
        if (rs) begin
            mState = 0; mX = 0; mJt = -1; mSub = 0; mDeadTicks = 0; mHit = 0;
            return;
        end
        if (mState == 0) begin
            if (jp && mJt < 0) mJt = 0;
            if (tk) begin
                if (mHit) begin
                    mState = 1; mX = startOf(mSub); mJt = -1; mDeadTicks = 0;
                    mDeaths = (mDeaths < 255) ? mDeaths + 1 : 255;
                end else begin
                    if (mJt >= 0) begin
                        mJt++;
                        if (mJt == 2*JUMP_H) mJt = -1;
                    end
                    if (mX == endOf(mSub)) begin
                        if (mSub == NSUB-1) begin
                            mState = 2; mSub = NSUB;
                        end else begin
                            mSub++; mX = startOf(mSub);
                        end
                    end else if (mSub % 2 == 0) begin
                        mX = (mX + STEP > endOf(mSub)) ? endOf(mSub) : mX + STEP;
                    end else begin
                        mX = (mX - STEP < endOf(mSub)) ? endOf(mSub) : mX - STEP;
                    end
                end
                mHit = 0;
            end else if (hitNow) begin
                mHit = 1;
            end
        end else if (mState == 1) begin
            if (tk) begin
                mHit = 0;
                mDeadTicks++;
                if (mDeadTicks == DEAD_FRAMES) begin
                    mState = 0; mDeadTicks = 0;
                end
            end
        end else if (tk) begin
            mHit = 0;
        end
    endfunction

    function automatic int actualOf(int kind);
        case (kind)
            K_COLOR:  return int'({vif.color[2], vif.color[1], vif.color[0]});
            K_SUB:    return int'(subLV);
            K_LVCP:   return int'(LVcp);
            K_DEATHS: return int'(deaths);
            K_DEAD:   return int'(dead);
            K_X:      return int'(dut.xQ);
            K_J:      return int'(dut.jOstQ);
            default:  return -1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int kind, input int exp);
        item_t it;
        it.name = name; it.kind = kind; it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic applyStimulus(input bit r, input bit rs, input bit tk, input bit jp,
                                 input bit pv, input int x, input int y);
        logic [11:0] expC;
        rst = r; restart = rs; imgReturn = tk; jump = jp;
        vif.pix_v = pv; vif.pix_x = x[PA-1:0]; vif.pix_y = y[PA-1:0];
        topColor = 12'($urandom); midColor = 12'($urandom);
        expC = r ? 12'h000 : expPal(pv, x, y);
        @(posedge clk);
        #1;
        modelStep(r, rs, tk, jp, pv, x, y);
        checkOutput("color", K_COLOR, int'(expC));
        checkOutput("subLV", K_SUB, mSub);
        checkOutput("LVcp", K_LVCP, (mState == 2) ? 1 : 0);
        checkOutput("deaths", K_DEATHS, mDeaths);
        checkOutput("dead", K_DEAD, (mState == 1) ? 1 : 0);
        checkOutput("posX", K_X, mX);
        checkOutput("jOst", K_J, mJost());
    endtask

    task automatic ticks(input int n);
        repeat (n) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic pixelNearPlayer(input bit pv);
        int x, y;
        x = mX + $urandom_range(0, 40) - 10;
        y = LANE_Y[(mSub < NSUB) ? mSub : 0] - mJost() + 8 - $urandom_range(0, 40);
        x = (x < 0) ? 0 : (x > SCR_W-1) ? SCR_W-1 : x;
        y = (y < 0) ? 0 : (y > 479) ? 479 : y;
        applyStimulus(0, 0, 0, 0, pv, x, y);
    endtask

    // Monitor: drain the scoreboard mid-cycle, well away from the clock edge.
    initial begin
        item_t it;
        int    act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                it  = sb.pop_front();
                act = actualOf(it.kind);
                nChecks++;
                if (act != it.exp) begin
                    nFails++;
                    $display("[TB] FAIL %s: got %0d, expected %0d", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic guardFail(input string name);
        nFails++;
        $display("[TB] FAIL %s: loop bound expired", name);
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        int guard;
        rst = 1'b1; imgReturn = 1'b0; jump = 1'b0; restart = 1'b0;
        topColor = '0; midColor = '0;
        vif.pix_v = 1'b0; vif.pix_x = '0; vif.pix_y = '0;
        modelStep(1, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset with conflicting requests");
        applyStimulus(1, 1, 1, 1, 1, 10, 110);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_color", K_COLOR, 0);
        checkOutput("reset_x", K_X, 0);
        checkOutput("reset_deaths", K_DEATHS, 0);

        $display("[TB] lane 0 traversal");
        for (int i = 0; i < 620; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 0);
            if (i % 60 == 0) begin
                pixelNearPlayer(1);
                pixelNearPlayer($urandom_range(0, 1));
                applyStimulus(0, 0, 0, 0, 1, $urandom_range(0, 639), $urandom_range(118, 125));
            end
        end
        checkOutput("lane0_end_x", K_X, 620);
        checkOutput("lane0_end_sub", K_SUB, 0);
        ticks(1);
        checkOutput("lane1_start_sub", K_SUB, 1);
        checkOutput("lane1_start_x", K_X, 620);

        $display("[TB] jump profile");
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int t = 1; t <= 80; t++) begin
            applyStimulus(0, 0, 1, (t == 10), 0, 0, 0);
            if (t == 40) checkOutput("jump_apex", K_J, 40);
            if (t == 20) pixelNearPlayer(1);
        end
        checkOutput("jump_landed", K_J, 0);
        checkOutput("after_jump_x", K_X, 540);

        $display("[TB] collision and respawn");
        guard = 0;
        while (mX != 310 && guard < 1000) begin ticks(1); guard++; end
        if (guard >= 1000) guardFail("reach_obstacle");
        applyStimulus(0, 0, 0, 0, 1, 312, 230);
        ticks(1);
        checkOutput("hit_dead", K_DEAD, 1);
        checkOutput("hit_deaths", K_DEATHS, 1);
        checkOutput("hit_respawn_x", K_X, 620);
        applyStimulus(0, 0, 0, 0, 1, 630, 230);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        ticks(29);
        checkOutput("still_dead", K_DEAD, 1);
        ticks(1);
        checkOutput("revived", K_DEAD, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("jump_with_tick", K_J, 1);
        ticks(79);

        $display("[TB] level completion");
        guard = 0;
        while (mState != 2 && guard < 3000) begin ticks(1); guard++; end
        if (guard >= 3000) guardFail("reach_done");
        checkOutput("done_lvcp", K_LVCP, 1);
        checkOutput("done_sub", K_SUB, 3);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        ticks(5);
        for (int i = 0; i < 6; i++) pixelNearPlayer(1);
        applyStimulus(0, 1, 1, 1, 0, 0, 0);
        checkOutput("restart_sub", K_SUB, 0);
        checkOutput("restart_lvcp", K_LVCP, 0);
        checkOutput("restart_deaths", K_DEATHS, 1);

        $display("[TB] death saturation");
        guard = 0;
        while (mSub != 2 && guard < 3000) begin ticks(1); guard++; end
        if (guard >= 3000) guardFail("reach_lane2");
        for (int d = 0; d < 256; d++) begin
            applyStimulus(0, 0, 0, 0, 1, 5, 355);
            ticks(1 + DEAD_FRAMES);
        end
        checkOutput("deaths_saturated", K_DEATHS, 255);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("deaths_after_rst", K_DEATHS, 0);

        $display("[TB] restart during jump");
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        ticks(15);
        checkOutput("midjump_x", K_X, 15);
        checkOutput("midjump_j", K_J, 15);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("restart_tick_x", K_X, 0);
        checkOutput("restart_tick_j", K_J, 0);
        checkOutput("restart_tick_sub", K_SUB, 0);

        $display("[TB] randomized run");
        for (int i = 0; i < 4000; i++) begin
            bit r  = ($urandom_range(0, 1999) == 0);
            bit rs = ($urandom_range(0, 1999) == 0);
            bit tk = ($urandom_range(0, 1) == 0);
            bit jp = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) != 0 && !r && !rs && !tk && !jp)
                pixelNearPlayer($urandom_range(0, 4) != 0);
            else
                applyStimulus(r, rs, tk, jp, $urandom_range(0, 1),
                              $urandom_range(0, 639), $urandom_range(0, 479));
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            nFails++;
            $display("[TB] FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
